// File: rtl/fp_div_iter_pkg.sv
// Shared constants, FSM state type and rounding-stage input record for the
// iterative floating-point divider.
package fp_div_iter_pkg;

    localparam int unsigned NQS = 27;        // single: 24 mantissa + guard + round + norm
    localparam int unsigned NQD = 56;        // double
    localparam int unsigned EW  = 14;        // signed biased exponent width
    localparam int unsigned MW  = 53;        // operand mantissa width, hidden bit at 52
    localparam int unsigned OW  = 54;        // rounding-stage mantissa width
    localparam int unsigned RW  = MW + 2;    // partial remainder width
    localparam int unsigned QW  = NQD;       // quotient register width
    localparam int unsigned CW  = 6;         // iteration counter width

    localparam logic [EW-1:0] BIAS_S = EW'(127);
    localparam logic [EW-1:0] BIAS_D = EW'(1023);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPEC,
        ST_ITER,
        ST_NORM,
        ST_DENORM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic          sig;
        logic [EW-1:0] expo;
        logic [OW-1:0] mant;
        logic [1:0]    rema;
        logic [1:0]    fmt;
        logic [2:0]    rm;
        logic [2:0]    grs;
        logic          snan;
        logic          qnan;
        logic          dbz;
        logic          inf;
        logic          zero;
        logic          diff;
    } rnd_t;

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/result bundle between the extract stage, the divider and the rounder.
interface fp_div_iter_if;
    import fp_div_iter_pkg::*;

    logic          start;
    logic          kill;
    logic [1:0]    fmt;
    logic [2:0]    rm;
    logic          a_sig;
    logic          b_sig;
    logic [EW-1:0] a_expo;
    logic [EW-1:0] b_expo;
    logic [MW-1:0] a_mant;
    logic [MW-1:0] b_mant;
    logic          a_snan;
    logic          a_qnan;
    logic          a_inf;
    logic          a_zero;
    logic          b_snan;
    logic          b_qnan;
    logic          b_inf;
    logic          b_zero;
    logic          ready;
    logic          valid;
    rnd_t          rnd_o;

    modport master (
        output start, kill, fmt, rm, a_sig, b_sig, a_expo, b_expo, a_mant, b_mant,
               a_snan, a_qnan, a_inf, a_zero, b_snan, b_qnan, b_inf, b_zero,
        input  ready, valid, rnd_o
    );

    modport slave (
        input  start, kill, fmt, rm, a_sig, b_sig, a_expo, b_expo, a_mant, b_mant,
               a_snan, a_qnan, a_inf, a_zero, b_snan, b_qnan, b_inf, b_zero,
        output ready, valid, rnd_o
    );

endinterface

// File: rtl/fp_div_step.sv
// One radix-2 restoring step: trial-subtract the divisor, pick the quotient
// bit from the sign, and shift the kept remainder left.
module fp_div_step
    import fp_div_iter_pkg::*;
(
    input  logic [RW-1:0] rem,
    input  logic [MW-1:0] dvsr,
    output logic [RW-1:0] rem_nx_c,
    output logic          qbit_c
);

    logic [RW-1:0] trial;

    // Remainder stays below 2^54, so the top bit of the difference is its sign.
    always_comb begin
        trial    = rem - {2'b00, dvsr};
        qbit_c   = ~trial[RW-1];
        rem_nx_c = (qbit_c ? trial : rem) << 1;
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative restoring mantissa divider (single/double) producing an unrounded
// record for the rounding stage, with special-operand and subnormal handling.
module fp_div_iter
    import fp_div_iter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fp_div_iter_if.slave bus
);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    fmt_q, fmt_nx;
    logic [2:0]    rm_q, rm_nx;
    logic          sig_q, sig_nx;
    logic [3:0]    acls, acls_nx;     // {snan, qnan, inf, zero}
    logic [3:0]    bcls, bcls_nx;
    logic [MW-1:0] dvsr, dvsr_nx;
    logic [RW-1:0] rem, rem_nx;
    logic [QW-1:0] quo, quo_nx;
    logic [EW-1:0] expo, expo_nx;
    logic [OW-1:0] mant, mant_nx;
    logic          g, g_nx, r, r_nx, s, s_nx;
    logic [4:0]    fl, fl_nx;         // {snan, qnan, dbz, inf, zero}
    logic          ready_nx, valid_nx;
    rnd_t          rnd_nx;

    logic [RW-1:0] step_rem;
    logic          step_q;
    logic          dbl;
    logic          quo_msb;
    logic [QW-1:0] quo_nrm;
    logic [EW-1:0] shamt;
    logic [EW-1:0] nq_lim;

    fp_div_step u_step (
        .rem      (rem),
        .dvsr     (dvsr),
        .rem_nx_c (step_rem),
        .qbit_c   (step_q)
    );

    always_comb begin
        dbl     = (fmt_q == 2'd1);
        quo_msb = dbl ? quo[NQD-1] : quo[NQS-1];
        quo_nrm = quo_msb ? quo : (quo << 1);
        shamt   = EW'(1) - expo;
        nq_lim  = dbl ? EW'(NQD) : EW'(NQS);
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fmt_nx   = fmt_q;
        rm_nx    = rm_q;
        sig_nx   = sig_q;
        acls_nx  = acls;
        bcls_nx  = bcls;
        dvsr_nx  = dvsr;
        rem_nx   = rem;
        quo_nx   = quo;
        expo_nx  = expo;
        mant_nx  = mant;
        g_nx     = g;
        r_nx     = r;
        s_nx     = s;
        fl_nx    = fl;
        valid_nx = 1'b0;
        rnd_nx   = bus.rnd_o;

        case (state)
            ST_IDLE: begin
                if (bus.start && !bus.kill) begin
                    fmt_nx  = bus.fmt;
                    rm_nx   = bus.rm;
                    sig_nx  = bus.a_sig ^ bus.b_sig;
                    acls_nx = {bus.a_snan, bus.a_qnan, bus.a_inf, bus.a_zero};
                    bcls_nx = {bus.b_snan, bus.b_qnan, bus.b_inf, bus.b_zero};
                    dvsr_nx = bus.b_mant;
                    rem_nx  = {2'b00, bus.a_mant};
                    quo_nx  = '0;
                    expo_nx = bus.a_expo - bus.b_expo + ((bus.fmt == 2'd1) ? BIAS_D : BIAS_S);
                    cnt_nx  = (bus.fmt == 2'd1) ? CW'(NQD - 1) : CW'(NQS - 1);
                    state_nx = (|{acls_nx, bcls_nx}) ? ST_SPEC : ST_ITER;
                end
            end
            ST_SPEC: begin
                expo_nx = '0;
                mant_nx = '0;
                g_nx    = 1'b0;
                r_nx    = 1'b0;
                s_nx    = 1'b0;
                if (acls[3] || bcls[3])                         fl_nx = 5'b10000;
                else if (acls[2] || bcls[2])                    fl_nx = 5'b01000;
                else if ((acls[1] && bcls[1]) || (acls[0] && bcls[0])) fl_nx = 5'b10000;
                else if (acls[1])                               fl_nx = 5'b00010;
                else if (bcls[0])                               fl_nx = 5'b00100;
                else                                            fl_nx = 5'b00001;
                state_nx = ST_DONE;
            end
            ST_ITER: begin
                rem_nx = step_rem;
                quo_nx = {quo[QW-2:0], step_q};
                if (cnt == '0) state_nx = ST_NORM;
                else           cnt_nx   = cnt - CW'(1);
            end
            ST_NORM: begin
                fl_nx   = '0;
                mant_nx = dbl ? OW'(quo_nrm[NQD-1:3]) : OW'(quo_nrm[NQS-1:3]);
                g_nx    = quo_nrm[2];
                r_nx    = quo_nrm[1];
                s_nx    = (rem != '0) || quo_nrm[0];
                if (!quo_msb) expo_nx = expo - EW'(1);
                state_nx = (expo_nx[EW-1] || expo_nx == '0) ? ST_DENORM : ST_DONE;
            end
            ST_DENORM: begin
                // Beyond the quotient width every mantissa bit is lost to sticky.
                if (shamt > nq_lim) begin
                    mant_nx  = '0;
                    g_nx     = 1'b0;
                    r_nx     = 1'b0;
                    s_nx     = 1'b1;
                    expo_nx  = '0;
                    state_nx = ST_DONE;
                end else begin
                    {mant_nx, g_nx, r_nx} = {mant, g, r} >> 1;
                    s_nx = s | r;
                    if (expo == '0) state_nx = ST_DONE;
                    else            expo_nx  = expo + EW'(1);
                end
            end
            ST_DONE: begin
                valid_nx    = 1'b1;
                rnd_nx.sig  = sig_q;
                rnd_nx.expo = expo;
                rnd_nx.mant = mant;
                rnd_nx.rema = 2'b00;
                rnd_nx.fmt  = fmt_q;
                rnd_nx.rm   = rm_q;
                rnd_nx.grs  = {g, r, s};
                {rnd_nx.snan, rnd_nx.qnan, rnd_nx.dbz, rnd_nx.inf, rnd_nx.zero} = fl;
                rnd_nx.diff = 1'b0;
                state_nx    = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        if (bus.kill && state != ST_IDLE) begin
            state_nx = ST_IDLE;
            valid_nx = 1'b0;
            rnd_nx   = bus.rnd_o;
        end

        ready_nx = (state_nx == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fmt_q     <= '0;
            rm_q      <= '0;
            sig_q     <= 1'b0;
            acls      <= '0;
            bcls      <= '0;
            dvsr      <= '0;
            rem       <= '0;
            quo       <= '0;
            expo      <= '0;
            mant      <= '0;
            g         <= 1'b0;
            r         <= 1'b0;
            s         <= 1'b0;
            fl        <= '0;
            bus.ready <= 1'b1;
            bus.valid <= 1'b0;
            bus.rnd_o <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fmt_q     <= fmt_nx;
            rm_q      <= rm_nx;
            sig_q     <= sig_nx;
            acls      <= acls_nx;
            bcls      <= bcls_nx;
            dvsr      <= dvsr_nx;
            rem       <= rem_nx;
            quo       <= quo_nx;
            expo      <= expo_nx;
            mant      <= mant_nx;
            g         <= g_nx;
            r         <= r_nx;
            s         <= s_nx;
            fl        <= fl_nx;
            bus.ready <= ready_nx;
            bus.valid <= valid_nx;
            bus.rnd_o <= rnd_nx;
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Randomized and directed bench for fp_div_iter against an arithmetic model
// built on exact integer division of the mantissas.
module tb_fp_div_iter;
    import fp_div_iter_pkg::*;

    typedef struct packed {
        logic [1:0]    fmt;
        logic [2:0]    rm;
        logic          a_sig;
        logic          b_sig;
        logic [EW-1:0] a_expo;
        logic [EW-1:0] b_expo;
        logic [MW-1:0] a_mant;
        logic [MW-1:0] b_mant;
        logic [3:0]    a_cls;   // {snan, qnan, inf, zero}
        logic [3:0]    b_cls;
    } op_t;

    localparam logic [MW-1:0] M_ONE  = 53'h10000000000000;
    localparam logic [MW-1:0] M_1P5  = 53'h18000000000000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fp_div_iter_if bus();

    fp_div_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [1:0] fmt, input logic as, input int ae,
                               input logic [MW-1:0] am, input logic [3:0] ac,
                               input logic bs, input int be,
                               input logic [MW-1:0] bm, input logic [3:0] bc);
        op_t o;
        o.fmt    = fmt;
        o.rm     = 3'd2;
        o.a_sig  = as;
        o.a_expo = EW'(ae);
        o.a_mant = am;
        o.a_cls  = ac;
        o.b_sig  = bs;
        o.b_expo = EW'(be);
        o.b_mant = bm;
        o.b_cls  = bc;
        return o;
    endfunction

    // Expected record and start-to-valid latency from the arithmetic definition.
    function automatic void model(input op_t o, output rnd_t res, output int lat);
        int n, e, sh;
        logic [127:0] num, q, rem, comb;
        logic st;
        res      = '0;
        res.sig  = o.a_sig ^ o.b_sig;
        res.fmt  = o.fmt;
        res.rm   = o.rm;
        if ((o.a_cls | o.b_cls) != 4'd0) begin
            lat = 2;
            if (o.a_cls[3] || o.b_cls[3])                                 res.snan = 1'b1;
            else if (o.a_cls[2] || o.b_cls[2])                            res.qnan = 1'b1;
            else if ((o.a_cls[1] && o.b_cls[1]) || (o.a_cls[0] && o.b_cls[0])) res.snan = 1'b1;
            else if (o.a_cls[1])                                          res.inf  = 1'b1;
            else if (o.b_cls[0])                                          res.dbz  = 1'b1;
            else                                                          res.zero = 1'b1;
            return;
        end
        n   = (o.fmt == 2'd1) ? 56 : 27;
        num = 128'(o.a_mant) << (n - 1);
        q   = num / 128'(o.b_mant);
        rem = num % 128'(o.b_mant);
        e   = int'($signed(o.a_expo)) - int'($signed(o.b_expo)) + ((o.fmt == 2'd1) ? 1023 : 127);
        if (q[n-1] == 1'b0) begin
            q = q << 1;
            e = e - 1;
        end
        st   = (rem != 128'd0) || q[0];
        comb = q >> 1;
        lat  = n + 2;
        if (e <= 0) begin
            sh = 1 - e;
            if (sh > n) begin
                comb = '0;
                st   = 1'b1;
                lat  = lat + 1;
            end else begin
                st   = st || ((comb & ((128'd1 << sh) - 128'd1)) != 128'd0);
                comb = comb >> sh;
                lat  = lat + sh;
            end
            e = 0;
        end
        res.expo = EW'(e);
        res.mant = OW'(comb >> 2);
        res.grs  = {comb[1], comb[0], st};
    endfunction

    task automatic drive(input op_t o);
        bus.fmt    = o.fmt;
        bus.rm     = o.rm;
        bus.a_sig  = o.a_sig;
        bus.b_sig  = o.b_sig;
        bus.a_expo = o.a_expo;
        bus.b_expo = o.b_expo;
        bus.a_mant = o.a_mant;
        bus.b_mant = o.b_mant;
        {bus.a_snan, bus.a_qnan, bus.a_inf, bus.a_zero} = o.a_cls;
        {bus.b_snan, bus.b_qnan, bus.b_inf, bus.b_zero} = o.b_cls;
    endtask

    // Issue one operation; optionally pulse start with other operands at cycle poke_at.
    task automatic run_op(input string tag, input op_t o, input int poke_at, output rnd_t res);
        rnd_t exp_r;
        int   exp_lat;
        int   cyc;
        logic seen;
        model(o, exp_r, exp_lat);
        @(negedge clock);
        drive(o);
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(posedge clock);
            #1 cyc++;
            if (bus.valid) seen = 1'b1;
            else if (cyc == poke_at) begin
                bus.start  = 1'b1;
                bus.b_mant = M_1P5;
                bus.a_expo = EW'(3);
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, "_seen"}, 128'(seen), 128'(1));
        check({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
        if ((o.a_cls | o.b_cls) != 4'd0)
            check({tag, "_spec"},
                  128'({bus.rnd_o.sig, bus.rnd_o.snan, bus.rnd_o.qnan, bus.rnd_o.dbz, bus.rnd_o.inf,
                        bus.rnd_o.zero, bus.rnd_o.fmt, bus.rnd_o.rm, bus.rnd_o.rema, bus.rnd_o.diff}),
                  128'({exp_r.sig, exp_r.snan, exp_r.qnan, exp_r.dbz, exp_r.inf,
                        exp_r.zero, exp_r.fmt, exp_r.rm, exp_r.rema, exp_r.diff}));
        else
            check({tag, "_rnd"}, 128'(bus.rnd_o), 128'(exp_r));
        res = bus.rnd_o;
        @(posedge clock);
        #1 check({tag, "_pulse"}, 128'(bus.valid), 128'(0));
    endtask

    function automatic op_t rand_op();
        op_t o;
        logic [63:0] rr;
        int dbl, bias, mode;
        dbl    = int'($urandom_range(0, 1));
        bias   = (dbl == 1) ? 1023 : 127;
        mode   = int'($urandom_range(0, 5));
        o      = '0;
        o.fmt  = (dbl == 1) ? 2'd1 : 2'd0;
        o.rm   = 3'($urandom_range(0, 4));
        o.a_sig = 1'($urandom);
        o.b_sig = 1'($urandom);
        rr = {$urandom, $urandom};
        o.a_mant = (dbl == 1) ? {1'b1, rr[51:0]} : {1'b1, rr[22:0], 29'd0};
        rr = {$urandom, $urandom};
        o.b_mant = (dbl == 1) ? {1'b1, rr[51:0]} : {1'b1, rr[22:0], 29'd0};
        if (mode <= 2) begin
            o.a_expo = EW'(bias - 100 + int'($urandom_range(0, 200)));
            o.b_expo = EW'(bias - 100 + int'($urandom_range(0, 200)));
        end else if (mode <= 4) begin
            o.a_expo = EW'(int'($urandom_range(0, 25)) - 20);
            o.b_expo = EW'(bias + int'($urandom_range(0, 64)));
        end else begin
            o.a_cls = 4'($urandom_range(0, 15));
            o.b_cls = 4'($urandom_range(0, 15));
            if (o.a_cls == 4'd0 && o.b_cls == 4'd0) o.b_cls = 4'b0001;
            o.a_expo = EW'(bias);
            o.b_expo = EW'(bias);
        end
        return o;
    endfunction

    initial begin
        rnd_t res, prev;
        logic seen;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        drive(mk(2'd0, 1'b0, 0, '0, 4'd0, 1'b0, 0, '0, 4'd0));
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 128'(bus.ready), 128'(1));
        check("rst_valid", 128'(bus.valid), 128'(0));
        check("rst_rnd", 128'(bus.rnd_o), 128'(0));
        @(negedge clock) reset = 1'b0;

        run_op("six_by_two", mk(2'd0, 1'b0, 129, M_1P5, 4'd0, 1'b0, 128, M_ONE, 4'd0), 0, res);
        check("six_expo", 128'(res.expo), 128'(128));
        check("six_mant", 128'(res.mant), 128'(24'hC00000));
        check("six_grs", 128'(res.grs), 128'(0));
        check("six_sig", 128'(res.sig), 128'(0));

        run_op("third", mk(2'd0, 1'b1, 127, M_ONE, 4'd0, 1'b0, 127, M_1P5, 4'd0), 0, res);
        check("third_expo", 128'(res.expo), 128'(126));
        check("third_mant", 128'(res.mant), 128'(24'hAAAAAA));
        check("third_grs", 128'(res.grs), 128'(3'b101));

        run_op("dbz", mk(2'd1, 1'b1, 1023, M_ONE, 4'd0, 1'b0, 0, '0, 4'b0001), 0, res);
        check("dbz_flag", 128'({res.dbz, res.sig}), 128'(2'b11));
        run_op("inf_inf", mk(2'd1, 1'b1, 0, M_ONE, 4'b0010, 1'b1, 0, M_ONE, 4'b0010), 0, res);
        check("inf_inf_flag", 128'({res.snan, res.sig}), 128'(2'b10));
        run_op("qnan_zero", mk(2'd1, 1'b0, 0, M_ONE, 4'b0100, 1'b1, 0, '0, 4'b0001), 0, res);
        check("qnan_zero_flag", 128'({res.qnan, res.snan, res.sig}), 128'(3'b101));

        run_op("denorm1", mk(2'd0, 1'b0, 1, M_ONE, 4'd0, 1'b0, 128, M_ONE, 4'd0), 0, res);
        check("denorm1_expo", 128'(res.expo), 128'(0));
        check("denorm1_mant", 128'(res.mant), 128'(24'h400000));
        check("denorm1_grs", 128'(res.grs), 128'(0));

        run_op("busy_poke", mk(2'd1, 1'b0, 1100, M_1P5, 4'd0, 1'b1, 1000, 53'h1C000000000001, 4'd0), 5, res);
        run_op("after_poke", mk(2'd0, 1'b1, 140, 53'h1E000000000000, 4'd0, 1'b1, 120, M_1P5, 4'd0), 0, res);

        // Kill mid-iteration: no result, ready back next cycle, record untouched.
        prev = bus.rnd_o;
        seen = 1'b0;
        @(negedge clock);
        drive(mk(2'd1, 1'b0, 1023, M_1P5, 4'd0, 1'b0, 1020, M_ONE, 4'd0));
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock);
            #1 if (bus.valid) seen = 1'b1;
        end
        bus.kill = 1'b1;
        @(posedge clock);
        #1 bus.kill = 1'b0;
        check("kill_ready", 128'(bus.ready), 128'(1));
        for (int c = 0; c < 70; c++) begin
            @(posedge clock);
            #1 if (bus.valid) seen = 1'b1;
        end
        check("kill_novalid", 128'(seen), 128'(0));
        check("kill_hold", 128'(bus.rnd_o), 128'(prev));
        run_op("after_kill", mk(2'd1, 1'b1, 1023, M_ONE, 4'd0, 1'b0, 1023, M_1P5, 4'd0), 0, res);

        // kill beats start in IDLE.
        @(negedge clock);
        bus.start = 1'b1;
        bus.kill  = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        check("kill_start_ready", 128'(bus.ready), 128'(1));

        for (int i = 0; i < 60; i++)
            run_op($sformatf("rand%0d", i), rand_op(), 0, res);

        // Synchronous reset during ITER clears everything.
        @(negedge clock);
        drive(mk(2'd0, 1'b0, 130, M_1P5, 4'd0, 1'b1, 127, M_ONE, 4'd0));
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_valid", 128'(bus.valid), 128'(0));
        check("midrst_ready", 128'(bus.ready), 128'(1));
        check("midrst_rnd", 128'(bus.rnd_o), 128'(0));
        reset = 1'b0;
        run_op("after_rst", mk(2'd0, 1'b0, 200, M_1P5, 4'd0, 1'b1, 10, 53'h1F000000000000, 4'd0), 0, res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
